// File: rtl/top_controller.sv
// Matrix-multiply engine C = A x B over three on-chip memories.
// One (i,j,k) operand read per cycle, single MAC pipeline, results streamed into MEM_C.

module top_mem_rd #(
  parameter int W     = 8,
  parameter int AW    = 12,
  parameter int DEPTH = 4096
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] array [0:DEPTH-1];

  always_ff @(posedge clk) begin
    rdata <= array[addr];
  end
endmodule

module top_mem_wr #(
  parameter int W     = 22,
  parameter int AW    = 12,
  parameter int DEPTH = 4096
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata
);
  logic [W-1:0] array [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) array[addr] <= wdata;
  end
endmodule

module top_controller #(
  parameter int N  = 64,
  parameter int DW = 8,
  parameter int OW = 22,
  parameter int AW = 12
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic done
);
  localparam int LW = $clog2(N);
  localparam logic [LW-1:0] KMAX = LW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t        state_q;
  logic [LW-1:0] i_q, j_q, k_q;
  logic          done_q;
  logic          issue, last_issue;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] rd_a, rd_b;

  logic          vld_p1_q, first_p1_q, last_p1_q, fin_p1_q;
  logic [AW-1:0] caddr_p1_q;
  logic signed [OW-1:0] acc_q, acc_d, prod_p1;

  logic          wr_p2_q, fin_p2_q;
  logic [AW-1:0] caddr_p2_q;
  logic [OW-1:0] wdata_p2_q;

  function automatic logic signed [OW-1:0] mul_sext(input logic [DW-1:0] a,
                                                    input logic [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = $signed(a) * $signed(b);
    return {{(OW-2*DW){p[2*DW-1]}}, p};
  endfunction

  assign issue      = (state_q == RUN);
  assign last_issue = issue && (i_q == KMAX) && (j_q == KMAX) && (k_q == KMAX);
  assign addr_a     = AW'({i_q, k_q});
  assign addr_b     = AW'({k_q, j_q});
  assign done       = done_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) state_q <= RUN;
        RUN: begin
          // Counters wrap back to zero naturally after the final (N-1,N-1,N-1) issue.
          k_q <= k_q + LW'(1);
          if (k_q == KMAX) begin
            j_q <= j_q + LW'(1);
            if (j_q == KMAX) i_q <= i_q + LW'(1);
          end
          if (last_issue) state_q <= FLUSH;
        end
        FLUSH: begin
          if (wr_p2_q && fin_p2_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  top_mem_rd #(.W(DW), .AW(AW), .DEPTH(N*N)) MEM_A (
    .clk(clk), .addr(addr_a), .rdata(rd_a)
  );
  top_mem_rd #(.W(DW), .AW(AW), .DEPTH(N*N)) MEM_B (
    .clk(clk), .addr(addr_b), .rdata(rd_b)
  );

  // p1: operands arrive from memory, MAC into the accumulator
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1_q <= 1'b0;
      wr_p2_q  <= 1'b0;
    end else begin
      vld_p1_q <= issue;
      wr_p2_q  <= vld_p1_q && last_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    first_p1_q <= (k_q == '0);
    last_p1_q  <= (k_q == KMAX);
    fin_p1_q   <= last_issue;
    caddr_p1_q <= AW'({i_q, j_q});
  end

  assign prod_p1 = mul_sext(rd_a, rd_b);

  always_comb begin
    acc_d = acc_q;
    if (vld_p1_q) acc_d = first_p1_q ? prod_p1 : acc_q + prod_p1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  // p2: completed element written to MEM_C while the next one accumulates
  always_ff @(posedge clk) begin
    fin_p2_q   <= fin_p1_q;
    caddr_p2_q <= caddr_p1_q;
    wdata_p2_q <= acc_d;
  end

  top_mem_wr #(.W(OW), .AW(AW), .DEPTH(N*N)) MEM_C (
    .clk(clk), .we(wr_p2_q), .addr(caddr_p2_q), .wdata(wdata_p2_q)
  );
endmodule

// File: tb/tb_top_controller.sv
// Randomized bench for top_controller, reduced to N=8 so many full runs fit in a short simulation.

module tb_top_controller;
  localparam int N     = 8;
  localparam int DW    = 8;
  localparam int OW    = 2*DW + $clog2(N);
  localparam int AW    = 2*$clog2(N);
  localparam int NN    = N*N;
  localparam int LIMIT = N*N*N + 8;

  logic clk = 1'b0;
  logic rstn;
  logic start;
  logic done;

  int n_chk = 0;
  int n_err = 0;

  byte ma [NN];
  byte mb [NN];
  int  mc [NN];

  top_controller #(.N(N), .DW(DW), .OW(OW), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: random A/B, 1: A=identity B=random, 2: all 0x7F, 3: all 0x80
  task automatic load(input int mode);
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        case (mode)
          1:       ma[i*N+k] = (i == k) ? 8'sd1 : 8'sd0;
          2:       ma[i*N+k] = 8'sh7F;
          3:       ma[i*N+k] = 8'sh80;
          default: ma[i*N+k] = byte'($urandom);
        endcase
        case (mode)
          2:       mb[i*N+k] = 8'sh7F;
          3:       mb[i*N+k] = 8'sh80;
          default: mb[i*N+k] = byte'($urandom);
        endcase
      end
    end
    for (int idx = 0; idx < NN; idx++) begin
      dut.MEM_A.array[idx] = ma[idx];
      dut.MEM_B.array[idx] = mb[idx];
    end
  endtask

  task automatic model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += int'(ma[i*N+k]) * int'(mb[k*N+j]);
        mc[i*N+j] = s;
      end
  endtask

  task automatic check_mem(input string tag);
    int bad;
    logic [OW-1:0] e;
    bad = 0;
    model();
    for (int idx = 0; idx < NN; idx++) begin
      e = OW'(mc[idx]);
      check_eq(tag, 32'(dut.MEM_C.array[idx]), 32'(e));
    end
  endtask

  task automatic check_const(input string tag, input int value);
    logic [OW-1:0] e;
    e = OW'(value);
    for (int idx = 0; idx < NN; idx++)
      check_eq(tag, 32'(dut.MEM_C.array[idx]), 32'(e));
  endtask

  // Pulses start, optionally re-pulses it while busy, and checks latency, width and uniqueness of done.
  task automatic run(input string tag, input bit repulse);
    int  c;
    int  extra;
    bit  seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    seen = 1'b0;
    while (c <= LIMIT) begin
      c++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      start = repulse && (c % 50 == 3);
      @(negedge clk);
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_latency_ok"}, 32'(c <= LIMIT), 32'd1);
    @(negedge clk);
    check_eq({tag, "_done_width"}, 32'(done), 32'd0);
    extra = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check_eq({tag, "_extra_done"}, 32'(extra), 32'd0);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int t = 0; t < cycles; t++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int cnt;
    rstn  = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_done", 32'(done), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_done", 32'(done), 32'd0);

    load(1);
    run("ident", 1'b0);
    for (int idx = 0; idx < NN; idx++) begin
      logic [OW-1:0] e;
      e = OW'(int'(mb[idx]));
      check_eq("ident_c", 32'(dut.MEM_C.array[idx]), 32'(e));
    end

    load(2);
    run("maxpos", 1'b0);
    check_const("maxpos_c", N * 16129);

    load(3);
    run("maxneg", 1'b0);
    check_const("maxneg_c", N * 16384);

    for (int r = 0; r < 3; r++) begin
      load(0);
      run("rand", 1'b0);
      check_mem("rand_c");
    end

    load(0);
    run("repulse", 1'b1);
    check_mem("repulse_c");

    // start held during the done cycle must not launch another run
    load(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int t = 0; t < LIMIT && !done; t++) @(negedge clk);
    check_eq("donecyc_done", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_done(LIMIT + 10, cnt);
    check_eq("donecyc_ignored", 32'(cnt), 32'd0);
    check_mem("donecyc_c");

    // abort mid-run with reset, then rerun on fresh data
    load(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rstn = 1'b0;
    count_done(5, cnt);
    check_eq("abort_done_low", 32'(cnt), 32'd0);
    rstn = 1'b1;
    count_done(LIMIT + 10, cnt);
    check_eq("abort_idle", 32'(cnt), 32'd0);
    run("rerun", 1'b0);
    check_mem("rerun_c");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
